// File: rtl/pl_io_trigger_gen.sv
// Trigger pulse generator for one PL I/O pin: optional delay, then a train of
// pulses with programmable width, period and count, started by software or an external edge.
module pl_io_trigger_gen #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             cfg_enable,
    input  logic             cfg_ext_mode,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [15:0]      cfg_count,
    input  logic             ext_trig_in,
    output logic             trig_out,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pulse_cnt
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_HIGH,
        S_LOW
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   delay_q;
    logic [CNT_W-1:0]   width_q;
    logic [CNT_W-1:0]   period_q;
    logic [15:0]        count_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        pulse_cnt_q;
    logic               trig_q;
    logic               busy_q;
    logic               done_q;

    logic [SYNC_N-1:0]  sync_q;
    logic               prev_q;
    logic               rise_q;

    logic [CNT_W-1:0]   cfg_w_eff;
    logic [CNT_W-1:0]   w_eff;
    logic [CNT_W-1:0]   low_len;
    logic [15:0]        pulse_inc;
    logic               last_pulse;

    // Effective phase lengths; zero width counts as one, LOW never shorter than one cycle.
    always_comb begin
        cfg_w_eff  = (cfg_width == '0) ? CNT_W'(1) : cfg_width;
        w_eff      = (width_q == '0) ? CNT_W'(1) : width_q;
        low_len    = (period_q > w_eff) ? (period_q - w_eff) : CNT_W'(1);
        pulse_inc  = (pulse_cnt_q == 16'hFFFF) ? pulse_cnt_q : (pulse_cnt_q + 16'd1);
        last_pulse = (count_q != 16'd0) && (pulse_cnt_q == count_q);
    end

    // External trigger synchronizer with a registered rising-edge flag.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], ext_trig_in};
            prev_q <= sync_q[SYNC_N-1];
            rise_q <= sync_q[SYNC_N-1] & ~prev_q;
        end
    end

    // Sequencer; cnt_q holds the remaining cycles of the current phase minus one.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            delay_q     <= '0;
            width_q     <= '0;
            period_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            pulse_cnt_q <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!cfg_enable) begin
                state_q <= S_IDLE;
                trig_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cfg_start) begin
                            delay_q     <= cfg_delay;
                            width_q     <= cfg_width;
                            period_q    <= cfg_period;
                            count_q     <= cfg_count;
                            pulse_cnt_q <= 16'd0;
                            busy_q      <= 1'b1;
                            if (cfg_ext_mode) begin
                                state_q <= S_ARMED;
                            end else if (cfg_delay == '0) begin
                                state_q     <= S_HIGH;
                                trig_q      <= 1'b1;
                                cnt_q       <= cfg_w_eff - CNT_W'(1);
                                pulse_cnt_q <= 16'd1;
                            end else begin
                                state_q <= S_DELAY;
                                cnt_q   <= cfg_delay - CNT_W'(1);
                            end
                        end
                    end
                    S_ARMED: begin
                        if (rise_q) begin
                            if (delay_q == '0) begin
                                state_q     <= S_HIGH;
                                trig_q      <= 1'b1;
                                cnt_q       <= w_eff - CNT_W'(1);
                                pulse_cnt_q <= pulse_inc;
                            end else begin
                                state_q <= S_DELAY;
                                cnt_q   <= delay_q - CNT_W'(1);
                            end
                        end
                    end
                    S_DELAY, S_LOW: begin
                        if (cnt_q == '0) begin
                            state_q     <= S_HIGH;
                            trig_q      <= 1'b1;
                            cnt_q       <= w_eff - CNT_W'(1);
                            pulse_cnt_q <= pulse_inc;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_HIGH: begin
                        if (cnt_q == '0) begin
                            trig_q <= 1'b0;
                            if (last_pulse) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_LOW;
                                cnt_q   <= low_len - CNT_W'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        trig_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign trig_out  = trig_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pl_io_trigger_gen.sv
// Directed bench for pl_io_trigger_gen: a vector table for back-to-back sequences
// plus hand-written reset, external-trigger and abort sequences.
module tb_pl_io_trigger_gen;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cfg_enable;
    logic        cfg_ext_mode;
    logic        cfg_start;
    logic [31:0] cfg_delay;
    logic [31:0] cfg_width;
    logic [31:0] cfg_period;
    logic [15:0] cfg_count;
    logic        ext_trig_in;
    logic        trig_out;
    logic        busy;
    logic        done;
    logic [15:0] pulse_cnt;

    int errors = 0;
    int checks = 0;

    pl_io_trigger_gen #(.CNT_W(32), .SYNC_STAGES(2)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cfg_enable  (cfg_enable),
        .cfg_ext_mode(cfg_ext_mode),
        .cfg_start   (cfg_start),
        .cfg_delay   (cfg_delay),
        .cfg_width   (cfg_width),
        .cfg_period  (cfg_period),
        .cfg_count   (cfg_count),
        .ext_trig_in (ext_trig_in),
        .trig_out    (trig_out),
        .busy        (busy),
        .done        (done),
        .pulse_cnt   (pulse_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        start;
        logic [31:0] delay;
        logic [31:0] width;
        logic [31:0] period;
        logic [15:0] count;
        logic        exp_trig;
        logic        exp_busy;
        logic        exp_done;
        logic [15:0] exp_pc;
    } row_t;

    row_t rows[32];

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_row(input int idx, input logic st, input int d, input int w, input int p,
                           input int c, input logic t, input logic b, input logic dn, input int pc);
        rows[idx].start    = st;
        rows[idx].delay    = 32'(d);
        rows[idx].width    = 32'(w);
        rows[idx].period   = 32'(p);
        rows[idx].count    = 16'(c);
        rows[idx].exp_trig = t;
        rows[idx].exp_busy = b;
        rows[idx].exp_done = dn;
        rows[idx].exp_pc   = 16'(pc);
    endtask

    initial begin
        // Burst: delay 3, width 2, period 5, count 3; row r drives cycle r, expects cycle r+1.
        set_row( 0, 1, 3, 2, 5, 3, 0, 1, 0, 0);
        set_row( 1, 0, 3, 2, 5, 3, 0, 1, 0, 0);
        set_row( 2, 0, 3, 2, 5, 3, 0, 1, 0, 0);
        set_row( 3, 0, 3, 2, 5, 3, 1, 1, 0, 1);
        set_row( 4, 0, 3, 2, 5, 3, 1, 1, 0, 1);
        set_row( 5, 0, 3, 2, 5, 3, 0, 1, 0, 1);
        set_row( 6, 0, 3, 2, 5, 3, 0, 1, 0, 1);
        set_row( 7, 0, 3, 2, 5, 3, 0, 1, 0, 1);
        set_row( 8, 0, 3, 2, 5, 3, 1, 1, 0, 2);
        set_row( 9, 0, 3, 2, 5, 3, 1, 1, 0, 2);
        set_row(10, 0, 3, 2, 5, 3, 0, 1, 0, 2);
        set_row(11, 0, 3, 2, 5, 3, 0, 1, 0, 2);
        set_row(12, 0, 3, 2, 5, 3, 0, 1, 0, 2);
        set_row(13, 0, 3, 2, 5, 3, 1, 1, 0, 3);
        set_row(14, 0, 3, 2, 5, 3, 1, 1, 0, 3);
        set_row(15, 0, 3, 2, 5, 3, 0, 0, 1, 3);
        // Restart in the done cycle: delay 0, width 0, period 0, count 2.
        set_row(16, 1, 0, 0, 0, 2, 1, 1, 0, 1);
        set_row(17, 0, 0, 0, 0, 2, 0, 1, 0, 1);
        set_row(18, 0, 0, 0, 0, 2, 1, 1, 0, 2);
        set_row(19, 0, 0, 0, 0, 2, 0, 0, 1, 2);
        set_row(20, 0, 0, 0, 0, 2, 0, 0, 0, 2);
        // Shadowing: width 2 latched, register rewritten to 8; a busy start is ignored.
        set_row(21, 1, 1, 2, 6, 2, 0, 1, 0, 0);
        set_row(22, 0, 1, 2, 6, 2, 1, 1, 0, 1);
        set_row(23, 0, 1, 8, 6, 2, 1, 1, 0, 1);
        set_row(24, 0, 1, 8, 6, 2, 0, 1, 0, 1);
        set_row(25, 1, 1, 8, 6, 2, 0, 1, 0, 1);
        set_row(26, 0, 1, 8, 6, 2, 0, 1, 0, 1);
        set_row(27, 0, 1, 8, 6, 2, 0, 1, 0, 1);
        set_row(28, 0, 1, 8, 6, 2, 1, 1, 0, 2);
        set_row(29, 0, 1, 8, 6, 2, 1, 1, 0, 2);
        set_row(30, 0, 1, 8, 6, 2, 0, 0, 1, 2);
        set_row(31, 0, 1, 8, 6, 2, 0, 0, 0, 2);

        ARESET       = 1'b1;
        cfg_enable   = 1'b1;
        cfg_ext_mode = 1'b0;
        cfg_start    = 1'b0;
        cfg_delay    = 32'd0;
        cfg_width    = 32'd1;
        cfg_period   = 32'd2;
        cfg_count    = 16'd1;
        ext_trig_in  = 1'b0;

        // Reset with start strobes toggling underneath it.
        for (int i = 0; i < 5; i++) begin
            cfg_start = (i % 2 == 0);
            tick();
            check($sformatf("reset%0d busy", i), 16'(busy), 16'd0);
            check($sformatf("reset%0d trig", i), 16'(trig_out), 16'd0);
        end
        check("reset done", 16'(done), 16'd0);
        check("reset pulse_cnt", pulse_cnt, 16'd0);
        cfg_start = 1'b0;
        ARESET    = 1'b0;
        tick();
        check("post-reset busy", 16'(busy), 16'd0);
        check("post-reset trig", 16'(trig_out), 16'd0);

        for (int r = 0; r < 32; r++) begin
            cfg_start  = rows[r].start;
            cfg_delay  = rows[r].delay;
            cfg_width  = rows[r].width;
            cfg_period = rows[r].period;
            cfg_count  = rows[r].count;
            tick();
            check($sformatf("row%0d trig", r), 16'(trig_out), 16'(rows[r].exp_trig));
            check($sformatf("row%0d busy", r), 16'(busy), 16'(rows[r].exp_busy));
            check($sformatf("row%0d done", r), 16'(done), 16'(rows[r].exp_done));
            check($sformatf("row%0d pulse_cnt", r), pulse_cnt, rows[r].exp_pc);
        end
        cfg_start = 1'b0;

        // External mode: an edge while idle must not start anything.
        cfg_ext_mode = 1'b1;
        cfg_delay    = 32'd0;
        cfg_width    = 32'd1;
        cfg_period   = 32'd4;
        cfg_count    = 16'd1;
        ext_trig_in  = 1'b1;
        repeat (3) tick();
        ext_trig_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("ext idle%0d trig", i), 16'(trig_out), 16'd0);
            check($sformatf("ext idle%0d busy", i), 16'(busy), 16'd0);
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("armed%0d busy", i), 16'(busy), 16'd1);
            check($sformatf("armed%0d trig", i), 16'(trig_out), 16'd0);
            tick();
        end
        // Edge presented at this clock: detected 3 cycles later, pulse on the 4th.
        ext_trig_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("ext sync%0d trig", i), 16'(trig_out), 16'd0);
        end
        tick();
        check("ext pulse trig", 16'(trig_out), 16'd1);
        check("ext pulse busy", 16'(busy), 16'd1);
        check("ext pulse pulse_cnt", pulse_cnt, 16'd1);
        tick();
        check("ext end trig", 16'(trig_out), 16'd0);
        check("ext end busy", 16'(busy), 16'd0);
        check("ext end done", 16'(done), 16'd1);
        ext_trig_in = 1'b0;
        tick();
        check("ext after done", 16'(done), 16'd0);

        // Abort mid-HIGH of a continuous train, then restart.
        cfg_ext_mode = 1'b0;
        cfg_delay    = 32'd2;
        cfg_width    = 32'd4;
        cfg_period   = 32'd10;
        cfg_count    = 16'd0;
        cfg_start    = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("abort busy", 16'(busy), 16'd1);
        tick();
        check("abort delay trig", 16'(trig_out), 16'd0);
        tick();
        check("abort high trig", 16'(trig_out), 16'd1);
        check("abort high pulse_cnt", pulse_cnt, 16'd1);
        tick();
        check("abort high2 trig", 16'(trig_out), 16'd1);
        cfg_enable = 1'b0;
        tick();
        check("abort trig", 16'(trig_out), 16'd0);
        check("abort busy low", 16'(busy), 16'd0);
        check("abort done", 16'(done), 16'd0);
        check("abort pulse_cnt", pulse_cnt, 16'd1);
        cfg_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("disabled%0d busy", i), 16'(busy), 16'd0);
            check($sformatf("disabled%0d done", i), 16'(done), 16'd0);
            check($sformatf("disabled%0d pulse_cnt", i), pulse_cnt, 16'd1);
        end
        cfg_start  = 1'b0;
        cfg_enable = 1'b1;
        tick();
        check("reenable busy", 16'(busy), 16'd0);
        cfg_delay = 32'd5;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("restart busy", 16'(busy), 16'd1);
        check("restart pulse_cnt", pulse_cnt, 16'd0);
        tick();
        check("restart trig", 16'(trig_out), 16'd0);
        cfg_enable = 1'b0;
        tick();
        check("final busy", 16'(busy), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
